mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shared 16x8 storage block with a single write port and a single synchronous read port, time-multiplexed among NREQ requesters by a round-robin arbiter.
- Each write is either a full word write or a single-bit masked write; reads return data one cycle after acceptance.
- Includes a clear sequencer that zero-fills the array after reset or on demand.
- Sits between a set of register-file-style clients and the storage they share.

Parameters:
- NREQ, 2, number of requesters (2..4)
- AW, 4, address width; DEPTH = 2**AW entries
- DW, 8, data width; bit index width BW = clog2(DW) = 3

Ports:
- clk  input  1  sole clock, all state on posedge
- rst_n  input  1  asynchronous active-low reset
- clr_req  input  1  pulse: start zero-fill of whole array
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept (one-hot or zero)
- req_we  input  NREQ  1 = write, 0 = read
- req_bitmode  input  NREQ  1 = single-bit write (ignored for reads)
- req_addr  input  NREQ*AW  packed, requester i at [i*AW +: AW]
- req_bit  input  NREQ*BW  packed bit index for bitmode writes
- req_wdata  input  NREQ*DW  packed write data; bitmode uses bit 0 only
- rsp_valid  output  NREQ  one-hot pulse: read data for requester i on rsp_data
- rsp_data  output  DW  registered read data
- busy  output  1  high while clear sequence runs

Behaviour:
- FSM states: CLEAR and RUN.
  - Reset enters CLEAR with clr_cnt = 0.
  - In CLEAR, one entry per cycle is written to 0 (mem[clr_cnt] <= 0), then clr_cnt increments.
  - After clr_cnt = DEPTH-1 is written, the FSM goes to RUN. CLEAR therefore lasts exactly DEPTH cycles.
- clr_req:
  - Sampled high in RUN: the next state is CLEAR with clr_cnt = 0. Any request accepted in that same cycle still completes.
  - High while already in CLEAR: ignored; the count does not restart.
- busy = (state == CLEAR). req_ready is all zero in CLEAR.
- Arbitration in RUN (combinational):
  - Grant goes to the first requester with req_valid = 1, searching from rr_ptr+1 upward modulo NREQ.
  - req_ready is asserted only for the granted requester; at most one accept per cycle.
  - req_ready may depend on req_valid.
  - rr_ptr updates to the granted index on every accept and holds otherwise. It resets to NREQ-1, so requester 0 has first priority.
- Word write (we=1, bitmode=0): mem[addr] <= wdata at the accepting edge.
- Bit write (we=1, bitmode=1): mem[addr][bit] <= wdata[0]; the other 7 bits of the entry are unchanged.
- Read (we=0):
  - At the accepting edge, rsp_data <= mem[addr] and rsp_valid <= one-hot of the granted index. rsp_valid is high for exactly 1 cycle.
  - Latency is 1 cycle. Back-to-back reads give back-to-back responses.
- Read-after-write: a read accepted in the cycle after a write to the same address returns the new value. No same-cycle conflict exists because there is one operation per cycle.
- rsp_data holds its last value when rsp_valid = 0.
- Reset values:
  - req_ready 0, rsp_valid 0, rsp_data 0, busy 1
  - state CLEAR, clr_cnt 0, rr_ptr NREQ-1
  - Memory is not reset directly; it is zeroed by the CLEAR sequence.
- Reset asserted mid-operation:
  - Pending and in-flight responses are dropped (rsp_valid goes to 0 immediately).
  - The clear sequence restarts from entry 0 after rst_n deasserts.
- Address arithmetic is AW bits wide and wraps. clr_cnt is AW bits wide; the terminal condition is clr_cnt == DEPTH-1.

Test Plan:
- Reset release, no requests -> busy=1 for exactly 16 cycles, then 0. Reads of all 16 addresses then return 8'h00.
- Req0 writes addr 3 = 8'hA5, next cycle req0 reads addr 3 -> rsp_valid=2'b01 one cycle after the read accept, rsp_data=8'hA5.
- Addr 5 = 8'hF0, then bit write addr 5 bit 1 value 1, then bit write bit 7 value 0, then read -> rsp_data=8'h72.
- Both requesters hold valid continuously, reading addrs 1 and 2 -> grants alternate 0,1,0,1. rsp_valid alternates 01,10. No requester is starved.
- clr_req pulsed in RUN while req1 read is accepted in the same cycle -> req1 still gets rsp_valid next cycle with old data. busy=1 for 16 cycles and req_ready=0 throughout; afterwards all entries read 0.
- rst_n dropped for 1 cycle while a read response is due -> rsp_valid stays 0, busy=1, and the full 16-cycle clear runs again.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/response bundle between NREQ clients and the shared store
interface mem_port_arbiter_if #(
   parameter int NREQ = 2,
   parameter int AW   = 4,
   parameter int DW   = 8,
   parameter int BW   = $clog2(DW)
);
   logic [NREQ-1:0]    req_valid, req_ready, req_we, req_bitmode, rsp_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*BW-1:0] req_bit;
   logic [NREQ*DW-1:0] req_wdata;
   logic [DW-1:0]      rsp_data;
   modport master (
      output req_valid, req_we, req_bitmode, req_addr, req_bit, req_wdata,
      input  req_ready, rsp_valid, rsp_data
   );
   modport slave (
      input  req_valid, req_we, req_bitmode, req_addr, req_bit, req_wdata,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin shared DEPTHxDW store with word/bit writes, 1-cycle reads and zero-fill sequencer
module mem_port_arbiter #(
   parameter int NREQ = 2,
   parameter int AW   = 4,
   parameter int DW   = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_req,
   output logic busy,
   mem_port_arbiter_if.slave bus
);
   localparam int BW    = $clog2(DW);
   localparam int DEPTH = 2 ** AW;
   localparam int PW    = NREQ > 1 ? $clog2(NREQ) : 1;
   typedef enum logic {CLEAR, RUN} state_t;
   state_t            state_q, state_d;
   logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d, gnt, cand;
   logic [NREQ-1:0]   gnt_oh, rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]     rsp_data_q, rsp_data_d;
   logic              found, accept, op_we, op_bm, mem_we;
   logic [AW-1:0]     op_addr, mem_addr;
   logic [BW-1:0]     op_bit;
   logic [DW-1:0]     op_wdata, rd_word, mem_wdata;
   logic [DW-1:0]     mem_q [DEPTH];
   // search starts just after the last winner so every requester gets a turn
   always_comb begin
      found = 1'b0;
      gnt   = rr_ptr_q;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = PW'((int'(rr_ptr_q) + k) % NREQ);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            gnt   = cand;
         end
      end
   end
   always_comb begin
      accept      = state_q == RUN && found;
      gnt_oh      = NREQ'(1) << gnt;
      op_we       = bus.req_we[gnt];
      op_bm       = bus.req_bitmode[gnt];
      op_addr     = bus.req_addr[gnt*AW +: AW];
      op_bit      = bus.req_bit[gnt*BW +: BW];
      op_wdata    = bus.req_wdata[gnt*DW +: DW];
      rd_word     = mem_q[op_addr];
      mem_we      = state_q == CLEAR || (accept && op_we);
      mem_addr    = state_q == CLEAR ? clr_cnt_q : op_addr;
      mem_wdata   = state_q == CLEAR ? '0 :
                    op_bm ? (rd_word & ~(DW'(1) << op_bit)) | (DW'(op_wdata[0]) << op_bit) : op_wdata;
      rsp_valid_d = accept && !op_we ? gnt_oh : '0;
      rsp_data_d  = accept && !op_we ? rd_word : rsp_data_q;
      rr_ptr_d    = accept ? gnt : rr_ptr_q;
   end
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == CLEAR) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == AW'(DEPTH - 1)) state_d = RUN;
      end else if (clr_req) begin
         state_d   = CLEAR;
         clr_cnt_d = '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CLEAR;
         clr_cnt_q   <= '0;
         rr_ptr_q    <= PW'(NREQ - 1);
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_addr] <= mem_wdata;
   end
   assign bus.req_ready = accept ? gnt_oh : '0;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign busy          = state_q == CLEAR;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with hand-computed expectations
module tb_mem_port_arbiter;
   logic clk = 1'b0, rst_n = 1'b0, clr_req = 1'b0, busy;
   int vectors = 0, miscompares = 0, n;
   logic [1:0] rdy_seen;
   mem_port_arbiter_if #(.NREQ(2), .AW(4), .DW(8)) bus ();
   mem_port_arbiter #(.NREQ(2), .AW(4), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy), .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic idle;
      bus.req_valid = '0;
   endtask
   task automatic set_req(input int i, input logic we, input logic bm, input logic [3:0] a,
                          input logic [2:0] b, input logic [7:0] d);
      bus.req_valid[i]       = 1'b1;
      bus.req_we[i]          = we;
      bus.req_bitmode[i]     = bm;
      bus.req_addr[i*4 +: 4] = a;
      bus.req_bit[i*3 +: 3]  = b;
      bus.req_wdata[i*8 +: 8] = d;
   endtask
   task automatic do_write(input int i, input logic bm, input logic [3:0] a, input logic [2:0] b,
                           input logic [7:0] d);
      set_req(i, 1'b1, bm, a, b, d);
      #1 chk("wr_ready", 32'(bus.req_ready), 32'(2'b01 << i));
      tick;
      idle;
   endtask
   task automatic do_read(input string tag, input int i, input logic [3:0] a, input logic [7:0] exp);
      set_req(i, 1'b0, 1'b0, a, 3'd0, 8'h00);
      #1 chk("rd_ready", 32'(bus.req_ready), 32'(2'b01 << i));
      tick;
      idle;
      chk({tag, "_vld"}, 32'(bus.rsp_valid), 32'(2'b01 << i));
      chk({tag, "_data"}, 32'(bus.rsp_data), 32'(exp));
   endtask
   task automatic count_clear(input string tag, input logic hold_valid);
      n = 0;
      rdy_seen = '0;
      while (busy === 1'b1 && n < 40) begin
         if (hold_valid) begin
            set_req(0, 1'b0, 1'b0, 4'd0, 3'd0, 8'h00);
            set_req(1, 1'b0, 1'b0, 4'd0, 3'd0, 8'h00);
            #1 rdy_seen |= bus.req_ready;
         end
         tick;
         n++;
      end
      idle;
      chk({tag, "_len"}, 32'(n), 32'd16);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      if (hold_valid) chk({tag, "_ready_during"}, 32'(rdy_seen), 32'd0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end
   initial begin
      bus.req_valid = '0; bus.req_we = '0; bus.req_bitmode = '0;
      bus.req_addr = '0; bus.req_bit = '0; bus.req_wdata = '0;
      #1;
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      tick; tick;
      rst_n = 1'b1;
      count_clear("init_clr", 1'b0);
      for (int a = 0; a < 16; a++) do_read("init_zero", a % 2, 4'(a), 8'h00);
      do_write(0, 1'b0, 4'd3, 3'd0, 8'hA5);
      do_read("raw_a5", 0, 4'd3, 8'hA5);
      do_write(0, 1'b0, 4'd5, 3'd0, 8'hF0);
      do_write(1, 1'b1, 4'd5, 3'd1, 8'h01);
      do_write(0, 1'b1, 4'd5, 3'd7, 8'hFE);
      do_read("bitwr_72", 1, 4'd5, 8'h72);
      tick;
      chk("hold_vld", 32'(bus.rsp_valid), 32'd0);
      chk("hold_data", 32'(bus.rsp_data), 32'h72);
      do_write(0, 1'b0, 4'd1, 3'd0, 8'h11);
      do_write(1, 1'b0, 4'd2, 3'd0, 8'h22);
      set_req(0, 1'b0, 1'b0, 4'd1, 3'd0, 8'h00);
      set_req(1, 1'b0, 1'b0, 4'd2, 3'd0, 8'h00);
      for (int k = 0; k < 4; k++) begin
         #1 chk("rr_ready", 32'(bus.req_ready), 32'(2'b01 << (k % 2)));
         tick;
         chk("rr_vld", 32'(bus.rsp_valid), 32'(2'b01 << (k % 2)));
         chk("rr_data", 32'(bus.rsp_data), k % 2 == 0 ? 32'h11 : 32'h22);
      end
      idle;
      set_req(1, 1'b0, 1'b0, 4'd1, 3'd0, 8'h00);
      clr_req = 1'b1;
      #1 chk("clr_acc_ready", 32'(bus.req_ready), 32'b10);
      tick;
      clr_req = 1'b0;
      idle;
      chk("clr_acc_vld", 32'(bus.rsp_valid), 32'b10);
      chk("clr_acc_data", 32'(bus.rsp_data), 32'h11);
      chk("clr_busy", 32'(busy), 32'd1);
      count_clear("req_clr", 1'b1);
      for (int a = 0; a < 16; a++) do_read("post_clr_zero", 1 - a % 2, 4'(a), 8'h00);
      do_write(0, 1'b0, 4'd7, 3'd0, 8'h5A);
      set_req(0, 1'b0, 1'b0, 4'd7, 3'd0, 8'h00);
      tick;
      idle;
      chk("pre_rst_vld", 32'(bus.rsp_valid), 32'b01);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd1);
      chk("mid_rst_data", 32'(bus.rsp_data), 32'd0);
      tick;
      rst_n = 1'b1;
      chk("rst_rel_vld", 32'(bus.rsp_valid), 32'd0);
      count_clear("rst_clr", 1'b0);
      do_read("rst_zero7", 0, 4'd7, 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
